aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule. Accepts a 128-bit cipher key and emits round keys 0..10 in order, one per accepted handshake.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_key_expand_if.sv | 29 ++
 rtl/aes_key_expand_gfunc.sv | 49 ++++
 rtl/aes_key_expand.sv | 127 ++++++++++++
 tb/tb_aes_key_expand.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam int unsigned AES128_NR = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } key_fsm_e;

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-schedule bus: start/key load, round-key handshake, done pulse and cache read port.
interface aes_key_expand_if
    import aes_pkg::*;
#(
    parameter int unsigned RND_W = 4
) ();

    logic             start;
    aes_block_t       key_in;
    logic             busy;
    logic             rk_valid;
    logic             rk_ready;
    aes_block_t       rk_key;
    logic [RND_W-1:0] rk_round;
    logic             done;
    logic [RND_W-1:0] rd_idx;
    aes_block_t       rd_key;

    modport master (
        output start, key_in, rk_ready, rd_idx,
        input  busy, rk_valid, rk_key, rk_round, done, rd_key
    );

    modport slave (
        input  start, key_in, rk_ready, rd_idx,
        output busy, rk_valid, rk_key, rk_round, done, rd_key
    );

endinterface

// File: rtl/aes_key_expand_gfunc.sv
// Key-schedule g function: RotWord, SubWord and Rcon on one word (purely combinational).
module aes_key_expand_gfunc
    import aes_pkg::*;
(
    input  logic [3:0] round_i,
    input  aes_word_t  w_i,
    output aes_word_t  g_o
);

    // Row-major S-box; entry 0 is the most significant byte of the literal.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8'd255 - x];
    endfunction

    logic [7:0] rcon;
    aes_word_t  rot;

    always_comb begin
        rcon = 8'h00;
        case (round_i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot = {w_i[23:0], w_i[31:24]};
    assign g_o = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule emitting round keys 0..NR over a valid/ready handshake.
// Optional round-key cache is enabled by defining AES_KEY_CACHE_EN.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES128_NR,
    parameter int unsigned RND_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    aes_key_expand_if.slave   bus
);

    if (NR != AES128_NR) begin : g_bad_nr
        $error("aes_key_expand: only NR=10 (AES-128) is supported");
    end
    if ((1 << RND_W) <= NR) begin : g_bad_rnd_w
        $error("aes_key_expand: RND_W too narrow for NR");
    end

    key_fsm_e         state_q, state_d;
    aes_block_t       rk_key_q, rk_key_d;
    logic [RND_W-1:0] rk_round_q, rk_round_d;
    logic             done_q, done_d;

    logic             hs;
    logic             last;
    logic [RND_W-1:0] g_round;
    aes_word_t        g_word;
    aes_word_t        w0n, w1n, w2n, w3n;

    assign hs   = (state_q == EMIT) && bus.rk_ready;
    assign last = (rk_round_q == RND_W'(NR));

    // Keep the g round in 1..NR even on the final key, where the result is discarded.
    assign g_round = last ? RND_W'(NR) : rk_round_q + RND_W'(1);

    aes_key_expand_gfunc u_gfunc (
        .round_i (4'(g_round)),
        .w_i     (rk_key_q[31:0]),
        .g_o     (g_word)
    );

    assign w0n = rk_key_q[127:96] ^ g_word;
    assign w1n = rk_key_q[95:64]  ^ w0n;
    assign w2n = rk_key_q[63:32]  ^ w1n;
    assign w3n = rk_key_q[31:0]   ^ w2n;

    always_comb begin
        state_d    = state_q;
        rk_key_d   = rk_key_q;
        rk_round_d = rk_round_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = EMIT;
                    rk_key_d   = bus.key_in;
                    rk_round_d = '0;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rk_key_d   = {w0n, w1n, w2n, w3n};
                        rk_round_d = rk_round_q + RND_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rk_key_q   <= '0;
            rk_round_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_key_q   <= rk_key_d;
            rk_round_q <= rk_round_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q == EMIT);
    assign bus.rk_valid = (state_q == EMIT);
    assign bus.rk_key   = rk_key_q;
    assign bus.rk_round = rk_round_q;
    assign bus.done     = done_q;

`ifdef AES_KEY_CACHE_EN
    aes_block_t cache_q [NR+1];
    aes_block_t cache_d [NR+1];

    always_comb begin
        cache_d = cache_q;
        if (hs) begin
            cache_d[rk_round_q] = rk_key_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                cache_q[i] <= '0;
            end
        end else begin
            cache_q <= cache_d;
        end
    end

    assign bus.rd_key = (bus.rd_idx <= RND_W'(NR)) ? cache_q[bus.rd_idx] : '0;
`else
    logic unused_rd_idx;
    logic unused_hs;
    assign unused_rd_idx = ^bus.rd_idx;
    assign unused_hs     = hs;
    assign bus.rd_key    = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and zero-key schedules, backpressure,
// ignored starts, asynchronous reset abort and the optional round-key cache.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    aes_key_expand_if #(.RND_W(4)) bus ();

    aes_key_expand #(
        .NR    (10),
        .RND_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int idx;

    logic [127:0] fips [11];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b0;
        bus.rd_idx   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(bus.busy), 128'(1'b0));
        chk("rst_valid", 128'(bus.rk_valid), 128'(1'b0));
        chk("rst_key", bus.rk_key, 128'h0);
        chk("rst_round", 128'(bus.rk_round), 128'(4'd0));
        chk("rst_done", 128'(bus.done), 128'(1'b0));
        chk("rst_rd_key", bus.rd_key, 128'h0);
        rst_n = 1'b1;

        // FIPS-197 schedule, consumer always ready; done lands 12 cycles after start
        @(negedge clk);
        bus.rk_ready = 1'b1;
        bus.key_in   = fips[0];
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = {4{32'hffffffff}};
        chk("fips_busy", 128'(bus.busy), 128'(1'b1));
        for (int r = 0; r <= 10; r++) begin
            chk($sformatf("fips_round%0d", r), 128'(bus.rk_round), 128'(r));
            chk($sformatf("fips_key%0d", r), bus.rk_key, fips[r]);
            chk($sformatf("fips_nodone%0d", r), 128'(bus.done), 128'(1'b0));
            if (r < 10) @(negedge clk);
        end
        @(negedge clk);
        chk("fips_done", 128'(bus.done), 128'(1'b1));
        chk("fips_done_busy", 128'(bus.busy), 128'(1'b0));
        chk("fips_done_valid", 128'(bus.rk_valid), 128'(1'b0));
        chk("fips_hold_key", bus.rk_key, fips[10]);
        chk("fips_hold_round", 128'(bus.rk_round), 128'(4'd10));
        @(negedge clk);
        chk("fips_done_pulse", 128'(bus.done), 128'(1'b0));
`ifdef AES_KEY_CACHE_EN
        bus.rd_idx = 4'd10;
        #1 chk("cache_rd10", bus.rd_key, fips[10]);
        bus.rd_idx = 4'd0;
        #1 chk("cache_rd0", bus.rd_key, fips[0]);
        bus.rd_idx = 4'd12;
        #1 chk("cache_rd12", bus.rd_key, 128'h0);
`else
        bus.rd_idx = 4'd10;
        #1 chk("nocache_rd10", bus.rd_key, 128'h0);
`endif
        bus.rd_idx = 4'd0;

        // All-zero key
        @(negedge clk);
        bus.key_in = '0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_key0", bus.rk_key, 128'h0);
        @(negedge clk);
        chk("zero_key1", bus.rk_key, 128'h62636363626363636263636362636363);
        repeat (9) @(negedge clk);
        chk("zero_round10", 128'(bus.rk_round), 128'(4'd10));
        chk("zero_key10", bus.rk_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        @(negedge clk);
        chk("zero_done", 128'(bus.done), 128'(1'b1));

        // Random backpressure: key held while not ready, rounds 0..10 once each in order
        @(negedge clk);
        bus.key_in   = fips[0];
        bus.start    = 1'b1;
        bus.rk_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < 11; cyc++) begin
            chk("bp_valid", 128'(bus.rk_valid), 128'(1'b1));
            chk("bp_round", 128'(bus.rk_round), 128'(idx));
            chk("bp_key", bus.rk_key, fips[idx]);
            bus.rk_ready = 1'($urandom_range(0, 1));
            if (bus.rk_ready) idx++;
            @(negedge clk);
        end
        chk("bp_rounds_seen", 128'(idx), 128'(11));
        chk("bp_done", 128'(bus.done), 128'(1'b1));

        // Start accepted in the done cycle, ignored mid-run and in the final handshake
        bus.rk_ready = 1'b1;
        bus.key_in   = fips[0];
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_valid", 128'(bus.rk_valid), 128'(1'b1));
        chk("ign_key0", bus.rk_key, fips[0]);
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            chk($sformatf("ign_round%0d", r), 128'(bus.rk_round), 128'(r));
            chk($sformatf("ign_key%0d", r), bus.rk_key, fips[r]);
            bus.start  = (r == 5) || (r == 10);
            bus.key_in = '0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_done", 128'(bus.done), 128'(1'b1));
        chk("ign_done_valid", 128'(bus.rk_valid), 128'(1'b0));
        @(negedge clk);
        chk("ign_final_start", 128'(bus.rk_valid), 128'(1'b0));
        chk("ign_final_key", bus.rk_key, fips[10]);

        // Asynchronous reset at round 4 aborts with no done
        bus.key_in = fips[0];
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_round4", 128'(bus.rk_round), 128'(4'd4));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(bus.busy), 128'(1'b0));
        chk("abort_valid", 128'(bus.rk_valid), 128'(1'b0));
        chk("abort_key", bus.rk_key, 128'h0);
        chk("abort_round", 128'(bus.rk_round), 128'(4'd0));
        chk("abort_done", 128'(bus.done), 128'(1'b0));
        @(posedge clk);
        #1 chk("abort_no_done", 128'(bus.done), 128'(1'b0));
`ifdef AES_KEY_CACHE_EN
        bus.rd_idx = 4'd3;
        #1 chk("abort_cache_clr", bus.rd_key, 128'h0);
        bus.rd_idx = 4'd0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.key_in = fips[0];
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_valid", 128'(bus.rk_valid), 128'(1'b1));
        chk("restart_round", 128'(bus.rk_round), 128'(4'd0));
        chk("restart_key", bus.rk_key, fips[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
